// File: rtl/alu_mul_seq_if.sv
// rtl/alu_mul_seq_if.sv - start/busy/done request bus plus the borrowed-ALU drive lines of the multiply sequencer
interface alu_mul_seq_if;
  logic        start;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        ovfl;
  logic        alu_req;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [4:0]  alu_ctrl;
  logic [15:0] alu_out;
  logic        alu_ovfl;

  modport master (
    output start, op_a, op_b, alu_out, alu_ovfl,
    input  busy, done, result, ovfl, alu_req, alu_a, alu_b, alu_ctrl
  );

  modport slave (
    input  start, op_a, op_b, alu_out, alu_ovfl,
    output busy, done, result, ovfl, alu_req, alu_a, alu_b, alu_ctrl
  );
endinterface

// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - shift-and-add 16x16 (low half) multiplier that borrows the shared CPU ALU
module alu_mul_seq (
  input  logic         clk,
  input  logic         rst,
  alu_mul_seq_if.slave bus
);
  localparam logic [4:0] ALU_ADD = 5'h00;
  localparam logic [4:0] ALU_SHL = 5'h05;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ADD   = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_mcand;
  logic [15:0] r_mplr;
  logic [15:0] r_acc;
  logic        r_ovf_acc;
  logic [15:0] r_result;
  logic        r_ovfl;
  logic [15:0] w_mplr_shr;

  assign w_mplr_shr = {1'b0, r_mplr[15:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    bus.alu_req  = 1'b0;
    bus.alu_a    = 16'h0000;
    bus.alu_b    = 16'h0000;
    bus.alu_ctrl = ALU_ADD;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_next = (bus.op_b == 16'h0000) ? S_DONE : S_ADD;
        end
      end
      S_ADD: begin
        bus.alu_req  = 1'b1;
        bus.alu_ctrl = ALU_ADD;
        bus.alu_a    = r_acc;
        bus.alu_b    = r_mcand;
        w_next       = S_SHIFT;
      end
      S_SHIFT: begin
        bus.alu_req  = 1'b1;
        bus.alu_ctrl = ALU_SHL;
        bus.alu_a    = r_mcand;
        bus.alu_b    = 16'h0001;
        w_next       = (w_mplr_shr == 16'h0000) ? S_DONE : S_ADD;
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // The ADD cycle is always spent; only a set multiplier bit commits the sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand   <= 16'h0000;
      r_mplr    <= 16'h0000;
      r_acc     <= 16'h0000;
      r_ovf_acc <= 1'b0;
      r_result  <= 16'h0000;
      r_ovfl    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_mcand   <= bus.op_a;
            r_mplr    <= bus.op_b;
            r_acc     <= 16'h0000;
            r_ovf_acc <= 1'b0;
          end
        end
        S_ADD: begin
          if (r_mplr[0]) begin
            r_acc     <= bus.alu_out;
            r_ovf_acc <= r_ovf_acc | bus.alu_ovfl;
          end
        end
        S_SHIFT: begin
          r_mcand <= bus.alu_out;
          r_mplr  <= w_mplr_shr;
        end
        S_DONE: begin
          r_result <= r_acc;
          r_ovfl   <= r_ovf_acc;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.busy   = (r_state != S_IDLE);
  assign bus.done   = (r_state == S_DONE);
  assign bus.result = r_result;
  assign bus.ovfl   = r_ovfl;
endmodule

// File: tb/tb_alu_mul_seq.sv
// tb/tb_alu_mul_seq.sv - directed-vector bench for alu_mul_seq with a behavioural shared ALU
module tb_alu_mul_seq;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  alu_mul_seq_if bus ();

  alu_mul_seq u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the CPU ALU: ADD with signed overflow, SHL by alu_b[3:0].
  logic [15:0] w_sum;
  always_comb begin
    w_sum        = bus.alu_a + bus.alu_b;
    bus.alu_out  = 16'h0000;
    bus.alu_ovfl = 1'b0;
    if (bus.alu_ctrl == 5'h00) begin
      bus.alu_out  = w_sum;
      bus.alu_ovfl = (bus.alu_a[15] == bus.alu_b[15]) && (w_sum[15] != bus.alu_a[15]);
    end else if (bus.alu_ctrl == 5'h05) begin
      bus.alu_out = bus.alu_a << bus.alu_b[3:0];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the sequencer idle; start is accepted at the next edge (cycle 0).
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input int exp_done, input logic [15:0] exp_res, input logic exp_ovf,
                        input int inj_cyc);
    int done_cyc;
    int req_cnt;
    bus.start = 1'b1;
    bus.op_a  = a;
    bus.op_b  = b;
    @(negedge clk);
    bus.start = 1'b0;
    done_cyc  = 0;
    req_cnt   = 0;
    for (int c = 1; c <= 40 && done_cyc == 0; c++) begin
      bus.start = (c == inj_cyc);
      if (c == inj_cyc) begin
        bus.op_a = 16'd9;
        bus.op_b = 16'd9;
      end
      if (bus.alu_req) req_cnt++;
      if (bus.done) done_cyc = c;
      else @(negedge clk);
    end
    bus.start = 1'b0;
    chk({tag, " done_cycle"}, done_cyc, exp_done);
    chk({tag, " alu_req_cycles"}, req_cnt, exp_done - 1);
    @(negedge clk);
    chk({tag, " result"}, bus.result, exp_res);
    chk({tag, " ovfl"}, bus.ovfl, exp_ovf);
    chk({tag, " busy_after"}, bus.busy, 1'b0);
  endtask

  initial begin
    int saw_done;
    n_checks  = 0;
    n_pass    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op_a  = 16'h0000;
    bus.op_b  = 16'h0000;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset busy", bus.busy, 1'b0);
    chk("reset done", bus.done, 1'b0);
    chk("reset alu_req", bus.alu_req, 1'b0);
    chk("reset result", bus.result, 16'h0000);
    chk("reset ovfl", bus.ovfl, 1'b0);

    run_op("3x5", 16'd3, 16'd5, 7, 16'h000F, 1'b0, 0);
    run_op("1234x0", 16'h1234, 16'h0000, 1, 16'h0000, 1'b0, 0);
    run_op("m3x7", 16'hFFFD, 16'd7, 7, 16'hFFEB, 1'b0, 0);
    run_op("3000x3", 16'h3000, 16'd3, 5, 16'h9000, 1'b1, 0);
    run_op("2x8000", 16'd2, 16'h8000, 33, 16'h0000, 1'b0, 4);
    run_op("FFFFxFFFF", 16'hFFFF, 16'hFFFF, 33, 16'h0001, 1'b1, 0);

    // Reset in cycle 3 of a 3x5 operation.
    bus.start = 1'b1;
    bus.op_a  = 16'd3;
    bus.op_b  = 16'd5;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst busy", bus.busy, 1'b0);
    chk("rst alu_req", bus.alu_req, 1'b0);
    chk("rst result", bus.result, 16'h0000);
    chk("rst ovfl", bus.ovfl, 1'b0);
    saw_done = 0;
    for (int c = 4; c <= 12; c++) begin
      if (bus.done) saw_done = 1;
      @(negedge clk);
    end
    chk("rst no_done", saw_done, 0);
    run_op("3x5 after rst", 16'd3, 16'd5, 7, 16'h000F, 1'b0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
